// File: rtl/sprite_mask_scanner_pkg.sv
// Shared sprite geometry constants and the {row,col} mask ROM address packing.
package sprite_mask_scanner_pkg;

  localparam int SPR_SIZE_LOG2 = 4;
  localparam int SPR_ADDR_W    = 8;
  localparam int COORD_W_DEF   = 10;

  function automatic logic [SPR_ADDR_W-1:0] pack_addr(
    input logic [SPR_SIZE_LOG2-1:0] row,
    input logic [SPR_SIZE_LOG2-1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/sprite_mask_scanner_if.sv
// Pixel-stream, sprite-setup and mask-ROM signals between the VGA side and the scanner.
interface sprite_mask_scanner_if #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 3
);
  import sprite_mask_scanner_pkg::*;

  logic                  i_frame_start;
  logic [COORD_W-1:0]    i_sprite_x;
  logic [COORD_W-1:0]    i_sprite_y;
  logic [COLOR_W-1:0]    i_sprite_color;
  logic                  i_pixel_valid;
  logic [COORD_W-1:0]    i_column;
  logic [COORD_W-1:0]    i_row;
  logic [SPR_ADDR_W-1:0] o_address;
  logic                  i_mask;
  logic                  o_pixel_valid;
  logic                  o_pixel_on;
  logic [COLOR_W-1:0]    o_color;
  logic                  o_hit;

  modport master (
    output i_frame_start, i_sprite_x, i_sprite_y, i_sprite_color,
    output i_pixel_valid, i_column, i_row, i_mask,
    input  o_address, o_pixel_valid, o_pixel_on, o_color, o_hit
  );

  modport slave (
    input  i_frame_start, i_sprite_x, i_sprite_y, i_sprite_color,
    input  i_pixel_valid, i_column, i_row, i_mask,
    output o_address, o_pixel_valid, o_pixel_on, o_color, o_hit
  );

endinterface

// File: rtl/sprite_mask_scanner_window_cmp.sv
// One-axis sprite window test: offset from origin, range check and texel index.
module sprite_window_cmp
  import sprite_mask_scanner_pkg::*;
#(
  parameter int COORD_W    = 10,
  parameter int SCALE_LOG2 = 0
) (
  input  logic [COORD_W-1:0]       i_coord,
  input  logic [COORD_W-1:0]       i_origin,
  output logic                     o_inside,
  output logic [SPR_SIZE_LOG2-1:0] o_index
);

  // One extra bit so a sprite near the far screen edge clips instead of wrapping.
  localparam logic [COORD_W:0] SPAN = (COORD_W+1)'(1 << (SPR_SIZE_LOG2 + SCALE_LOG2));

  logic [COORD_W:0] w_coord;
  logic [COORD_W:0] w_origin;
  logic [COORD_W:0] w_diff;
  logic [COORD_W:0] w_end;

  assign w_coord  = {1'b0, i_coord};
  assign w_origin = {1'b0, i_origin};
  assign w_diff   = w_coord - w_origin;
  assign w_end    = w_origin + SPAN;
  assign o_inside = (w_coord >= w_origin) && (w_coord < w_end);
  assign o_index  = SPR_SIZE_LOG2'(w_diff >> SCALE_LOG2);

endmodule

// File: rtl/sprite_mask_scanner.sv
// Two-stage sprite mask scanner: drives the mask ROM address per visible pixel and
// emits the sprite-on flag, colour and a per-frame sticky hit.
module sprite_mask_scanner
  import sprite_mask_scanner_pkg::*;
#(
  parameter int   COORD_W     = COORD_W_DEF,
  parameter int   COLOR_W     = 3,
  parameter int   SCALE_LOG2  = 0,
  parameter logic TRANSPARENT = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  sprite_mask_scanner_if.slave  io_px
);

  logic [COORD_W-1:0]       r_pos_x;
  logic [COORD_W-1:0]       r_pos_y;
  logic [COLOR_W-1:0]       r_color;
  logic [SPR_ADDR_W-1:0]    r_address;
  logic                     r_valid_d1;
  logic                     r_inside_d1;
  logic                     r_pixel_valid;
  logic                     r_pixel_on;
  logic [COLOR_W-1:0]       r_color_out;
  logic                     r_hit;

  logic                     w_inside_x;
  logic                     w_inside_y;
  logic [SPR_SIZE_LOG2-1:0] w_tex_col;
  logic [SPR_SIZE_LOG2-1:0] w_tex_row;
  logic                     w_hit_pixel;
  logic                     w_on_next;

  sprite_window_cmp #(.COORD_W(COORD_W), .SCALE_LOG2(SCALE_LOG2)) u_cmp_x (
    .i_coord  (io_px.i_column),
    .i_origin (r_pos_x),
    .o_inside (w_inside_x),
    .o_index  (w_tex_col)
  );

  sprite_window_cmp #(.COORD_W(COORD_W), .SCALE_LOG2(SCALE_LOG2)) u_cmp_y (
    .i_coord  (io_px.i_row),
    .i_origin (r_pos_y),
    .o_inside (w_inside_y),
    .o_index  (w_tex_row)
  );

  assign w_hit_pixel = io_px.i_pixel_valid & w_inside_x & w_inside_y;
  assign w_on_next   = r_valid_d1 & r_inside_d1 & (io_px.i_mask != TRANSPARENT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pos_x       <= {COORD_W{1'b0}};
      r_pos_y       <= {COORD_W{1'b0}};
      r_color       <= {COLOR_W{1'b0}};
      r_address     <= {SPR_ADDR_W{1'b0}};
      r_valid_d1    <= 1'b0;
      r_inside_d1   <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_pixel_on    <= 1'b0;
      r_color_out   <= {COLOR_W{1'b0}};
      r_hit         <= 1'b0;
    end else begin
      // Pixels in the frame-start cycle still see the old position.
      if (io_px.i_frame_start) begin
        r_pos_x <= io_px.i_sprite_x;
        r_pos_y <= io_px.i_sprite_y;
        r_color <= io_px.i_sprite_color;
      end
      if (w_hit_pixel) begin
        r_address <= pack_addr(w_tex_row, w_tex_col);
      end
      r_valid_d1    <= io_px.i_pixel_valid;
      r_inside_d1   <= w_hit_pixel;
      r_pixel_valid <= r_valid_d1;
      r_pixel_on    <= w_on_next;
      r_color_out   <= w_on_next ? r_color : {COLOR_W{1'b0}};
      // A pixel leaving the pipe in the frame-start cycle belongs to the old frame.
      if (io_px.i_frame_start) begin
        r_hit <= 1'b0;
      end else if (w_on_next) begin
        r_hit <= 1'b1;
      end
    end
  end

  assign io_px.o_address     = r_address;
  assign io_px.o_pixel_valid = r_pixel_valid;
  assign io_px.o_pixel_on    = r_pixel_on;
  assign io_px.o_color       = r_color_out;
  assign io_px.o_hit         = r_hit;

endmodule

// File: tb/tb_sprite_mask_scanner.sv
// Directed bench: SCALE_LOG2=0 and SCALE_LOG2=1 scanners share one pixel stream,
// each fed by a model mask ROM.
module tb_sprite_mask_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fs = 1'b0;
  logic [9:0] sx = 10'd0;
  logic [9:0] sy = 10'd0;
  logic [2:0] scol = 3'd0;
  logic       pv = 1'b0;
  logic [9:0] col = 10'd0;
  logic [9:0] row = 10'd0;
  logic       force0 = 1'b0;
  int         n_err = 0;
  int         n_chk = 0;

  always #5 clk = ~clk;

  sprite_mask_scanner_if #(.COORD_W(10), .COLOR_W(3)) if0 ();
  sprite_mask_scanner_if #(.COORD_W(10), .COLOR_W(3)) if1 ();

  // Model ROM: transparent where address bits 0 and 4 agree.
  function automatic logic rom_mask(input logic [7:0] a);
    return ~(a[0] ^ a[4]);
  endfunction

  assign if0.i_frame_start  = fs;
  assign if0.i_sprite_x     = sx;
  assign if0.i_sprite_y     = sy;
  assign if0.i_sprite_color = scol;
  assign if0.i_pixel_valid  = pv;
  assign if0.i_column       = col;
  assign if0.i_row          = row;
  assign if0.i_mask         = force0 ? 1'b0 : rom_mask(if0.o_address);
  assign if1.i_frame_start  = fs;
  assign if1.i_sprite_x     = sx;
  assign if1.i_sprite_y     = sy;
  assign if1.i_sprite_color = scol;
  assign if1.i_pixel_valid  = pv;
  assign if1.i_column       = col;
  assign if1.i_row          = row;
  assign if1.i_mask         = force0 ? 1'b0 : rom_mask(if1.o_address);

  sprite_mask_scanner #(.COORD_W(10), .COLOR_W(3), .SCALE_LOG2(0), .TRANSPARENT(1'b1))
    dut0 (.i_clk(clk), .i_rst(rst), .io_px(if0.slave));
  sprite_mask_scanner #(.COORD_W(10), .COLOR_W(3), .SCALE_LOG2(1), .TRANSPARENT(1'b1))
    dut1 (.i_clk(clk), .i_rst(rst), .io_px(if1.slave));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic frame_start(input logic [9:0] x, input logic [9:0] y, input logic [2:0] c);
    @(negedge clk);
    fs = 1'b1; sx = x; sy = y; scol = c;
    @(posedge clk); #1;
    @(negedge clk);
    fs = 1'b0;
  endtask

  // Present one pixel, check the ROM address one cycle later and the output a cycle after that.
  task automatic pix(input int sel, input int x, input int y, input logic f0,
                     input logic [7:0] exp_addr, input logic exp_on, input logic exp_hit);
    @(negedge clk);
    pv = 1'b1; col = 10'(x); row = 10'(y); force0 = f0;
    @(posedge clk); #1;
    check_eq($sformatf("addr(%0d,%0d)", x, y), sel != 0 ? if1.o_address : if0.o_address, exp_addr);
    @(negedge clk);
    pv = 1'b0;
    @(posedge clk); #1;
    check_eq($sformatf("valid(%0d,%0d)", x, y), sel != 0 ? if1.o_pixel_valid : if0.o_pixel_valid, 1'b1);
    check_eq($sformatf("on(%0d,%0d)", x, y), sel != 0 ? if1.o_pixel_on : if0.o_pixel_on, exp_on);
    check_eq($sformatf("color(%0d,%0d)", x, y), sel != 0 ? if1.o_color : if0.o_color,
             exp_on ? 3'b101 : 3'b000);
    check_eq($sformatf("hit(%0d,%0d)", x, y), sel != 0 ? if1.o_hit : if0.o_hit, exp_hit);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_addr"},  if0.o_address, 8'h00);
    check_eq({tag, "_valid"}, if0.o_pixel_valid, 1'b0);
    check_eq({tag, "_on"},    if0.o_pixel_on, 1'b0);
    check_eq({tag, "_color"}, if0.o_color, 3'b000);
    check_eq({tag, "_hit"},   if0.o_hit, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 check_zero("rst");
    @(negedge clk);
    rst = 1'b0;

    // Basic drawing and window edges, unscaled.
    frame_start(10'd100, 10'd50, 3'b101);
    check_eq("hit_after_fs", if0.o_hit, 1'b0);
    pix(0, 100, 50, 1'b0, 8'h00, 1'b0, 1'b0);
    pix(0, 103, 50, 1'b0, 8'h03, 1'b1, 1'b1);
    pix(0, 115, 65, 1'b1, 8'hFF, 1'b1, 1'b1);
    pix(0,  99, 50, 1'b1, 8'hFF, 1'b0, 1'b1);
    pix(0, 116, 50, 1'b1, 8'hFF, 1'b0, 1'b1);
    pix(0, 100, 66, 1'b1, 8'hFF, 1'b0, 1'b1);

    // Reset for two cycles in the middle of an active line.
    @(negedge clk);
    pv = 1'b1; col = 10'd100; row = 10'd50; force0 = 1'b1;
    @(negedge clk); col = 10'd101;
    @(negedge clk); col = 10'd102; rst = 1'b1;
    @(posedge clk); #1 check_zero("midrst");
    @(negedge clk); col = 10'd103;
    @(posedge clk); #1 check_zero("midrst2");
    @(negedge clk); col = 10'd104; rst = 1'b0;
    @(posedge clk); #1 check_eq("resume_lat1", if0.o_pixel_valid, 1'b0);
    @(negedge clk); pv = 1'b0;
    @(posedge clk); #1 check_eq("resume_lat2", if0.o_pixel_valid, 1'b1);
    check_eq("resume_on", if0.o_pixel_on, 1'b0);

    // Scaled sprite (2x2 screen pixels per texel).
    frame_start(10'd100, 10'd50, 3'b101);
    pix(1, 107, 53, 1'b0, 8'h13, 1'b0, 1'b0);
    pix(1, 131, 50, 1'b0, 8'h0F, 1'b1, 1'b1);
    pix(1, 132, 50, 1'b1, 8'h0F, 1'b0, 1'b1);

    // Right-edge clip must not wrap onto the left of the line.
    frame_start(10'd630, 10'd50, 3'b101);
    pix(0, 639, 50, 1'b0, 8'h09, 1'b1, 1'b1);
    for (int x = 0; x <= 5; x++) begin
      pix(0, x, 50, 1'b1, 8'h09, 1'b0, 1'b1);
    end

    // Frame start coinciding with a pixel: old position for that pixel, clear wins over set.
    frame_start(10'd100, 10'd50, 3'b101);
    check_eq("fs_clear", if0.o_hit, 1'b0);
    @(negedge clk);
    pv = 1'b1; col = 10'd103; row = 10'd50; force0 = 1'b0;
    @(posedge clk); #1 check_eq("same_a_addr", if0.o_address, 8'h03);
    @(negedge clk);
    fs = 1'b1; sx = 10'd200; sy = 10'd50;
    @(posedge clk); #1;
    check_eq("same_b_addr", if0.o_address, 8'h03);
    check_eq("same_a_on", if0.o_pixel_on, 1'b1);
    check_eq("same_clr_prio", if0.o_hit, 1'b0);
    @(negedge clk);
    fs = 1'b0; pv = 1'b0;
    @(posedge clk); #1;
    check_eq("same_b_on", if0.o_pixel_on, 1'b1);
    check_eq("same_b_hit", if0.o_hit, 1'b1);
    pix(0, 200, 50, 1'b0, 8'h00, 1'b0, 1'b1);
    pix(0, 203, 50, 1'b0, 8'h03, 1'b1, 1'b1);
    pix(0, 100, 50, 1'b1, 8'h03, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
